cga_video_dac: RTL and testbench

Parametrised CGA output stage between the CGA sequencer and the scan doubler / VGA port. It converts a 4-bit RGBI pixel stream into OUT_W-bit-per-channel RGB through one of three paths: a run-time programmable 16-entry palette, an NTSC composite artifact-colour approximation with a TAPS-deep running filter, or monochrome green. Output RGB and sync are registered with a fixed, mode-independent latency, so downstream timing never changes.

---
 rtl/cga_video_dac_if.sv | 30 +++
 rtl/cga_video_dac.sv | 202 ++++++++++++++++++++
 tb/tb_cga_video_dac.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cga_video_dac_if.sv
// Pixel stream, palette write port and registered RGB/sync outputs of the CGA output stage.
interface cga_video_dac_if #(
  parameter int OUT_W = 6
);
  logic               pix_en;
  logic [3:0]         video;
  logic               blank;
  logic               hsync;
  logic               vsync;
  logic [1:0]         mode;
  logic               pal_we;
  logic [3:0]         pal_addr;
  logic [3*OUT_W-1:0] pal_data;
  logic [OUT_W-1:0]   red;
  logic [OUT_W-1:0]   green;
  logic [OUT_W-1:0]   blue;
  logic               hsync_out;
  logic               vsync_out;
  logic               de_out;

  modport master (
    output pix_en, video, blank, hsync, vsync, mode, pal_we, pal_addr, pal_data,
    input  red, green, blue, hsync_out, vsync_out, de_out
  );

  modport slave (
    input  pix_en, video, blank, hsync, vsync, mode, pal_we, pal_addr, pal_data,
    output red, green, blue, hsync_out, vsync_out, de_out
  );
endinterface

// File: rtl/cga_video_dac.sv
// CGA RGBI to RGB output stage: palette, composite artifact colour or mono green,
// with a fixed 3-strobe pipeline so downstream timing never depends on mode.
module cga_video_dac #(
  parameter int OUT_W      = 6,
  parameter int TAPS       = 8,
  parameter int LUMA_HI    = 21,
  parameter int CHROMA_AMP = 50
) (
  input logic            clk,
  input logic            reset_n,
  cga_video_dac_if.slave vif
);
  localparam int PW    = 3*OUT_W;
  localparam int LOG2T = $clog2(TAPS);
  localparam int SW    = 10;
  localparam int PRW   = 18;
  localparam logic [SW-1:0] LUMA_V   = SW'(LUMA_HI);
  localparam logic [SW-1:0] CHROMA_V = SW'(CHROMA_AMP);

  function automatic logic [OUT_W-1:0] scale6(input logic [5:0] v);
    logic [7:0] w;
    w = {v, 2'b00};
    return w[7 -: OUT_W];
  endfunction

  // Standard CGA colours; entry 6 uses half green to give brown instead of dark yellow.
  function automatic logic [PW-1:0] pal_default(input logic [3:0] idx);
    logic [5:0] lo, r, g, b;
    lo = idx[3] ? 6'h15 : 6'h00;
    r  = lo + (idx[2] ? 6'h2A : 6'h00);
    g  = (idx == 4'h6) ? 6'h15 : lo + (idx[1] ? 6'h2A : 6'h00);
    b  = lo + (idx[0] ? 6'h2A : 6'h00);
    return {scale6(b), scale6(g), scale6(r)};
  endfunction

  function automatic logic [7:0] mask_row(input logic [2:0] idx);
    logic [7:0] m;
    case (idx)
      3'd0: m = 8'h00;  3'd1: m = 8'h0F;  3'd2: m = 8'h1E;  3'd3: m = 8'h3C;
      3'd4: m = 8'hF0;  3'd5: m = 8'hE1;  3'd6: m = 8'h78;  default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic signed [7:0] cos_at(input logic [2:0] p);
    logic signed [7:0] c;
    case (p)
      3'd0: c = 8'sd16;   3'd1: c = 8'sd53;   3'd2: c = 8'sd64;   3'd3: c = 8'sd36;
      3'd4: c = -8'sd8;   3'd5: c = -8'sd50;  3'd6: c = -8'sd32;  default: c = -8'sd45;
    endcase
    return c;
  endfunction

  function automatic logic signed [7:0] sin_at(input logic [2:0] p);
    logic signed [7:0] s;
    case (p)
      3'd0: s = -8'sd64;  3'd1: s = -8'sd32;  3'd2: s = 8'sd12;   3'd3: s = 8'sd51;
      3'd4: s = 8'sd64;   3'd5: s = 8'sd40;   3'd6: s = 8'sd0;    default: s = -8'sd30;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [21:0] x);
    if (x < 0) return 8'd0;
    if (x > 22'sd255) return 8'hFF;
    return x[7:0];
  endfunction

  logic [PW-1:0]         pal_q [16], pal_d [16];
  logic [2:0]            p_q, p_d;
  logic [LOG2T-1:0]      ptr_q, ptr_d;
  logic [SW-1:0]         hy_q [TAPS], hy_d [TAPS];
  logic signed [PRW-1:0] hi_q [TAPS], hi_d [TAPS];
  logic signed [PRW-1:0] hq_q [TAPS], hq_d [TAPS];
  logic signed [19:0]    sy_q, sy_d, si_q, si_d, sq_q, sq_d;
  logic [3:0]            v1_q, v1_d;
  logic                  blank1_q, blank1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [1:0]            mode1_q, mode1_d;
  logic [PW-1:0]         pal1_q, pal1_d;
  logic [OUT_W-1:0]      r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic                  hs2_q, hs2_d, vs2_q, vs2_d;
  logic [OUT_W-1:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                  hso_q, hso_d, vso_q, vso_d, de_q, de_d;

  logic                  hs_rise;
  logic [7:0]            mask_w;
  logic [SW-1:0]         s_new;
  logic signed [PRW-1:0] i_new, q_new;
  logic signed [19:0]    y_w, i_w, q_w;
  logic signed [21:0]    cr, cg, cb;
  logic [7:0]            comp_r, comp_g, comp_b, mono;

  always_comb begin
    pal_d = pal_q;
    if (vif.pal_we) pal_d[vif.pal_addr] = vif.pal_data;

    hs_rise = vif.hsync & ~hs1_q;
    mask_w  = mask_row(vif.video[2:0]);
    s_new   = '0;
    if (!vif.blank) begin
      if (vif.video[3]) s_new = s_new + LUMA_V;
      if (mask_w[p_q])  s_new = s_new + CHROMA_V;
    end
    i_new = PRW'($signed({1'b0, s_new})) * PRW'(cos_at(p_q));
    q_new = PRW'($signed({1'b0, s_new})) * PRW'(sin_at(p_q));

    // Composite decode reads the sums left by the pixel now sitting in stage 1.
    y_w    = sy_q >>> (LOG2T-2);
    i_w    = si_q >>> (LOG2T-1);
    q_w    = sq_q >>> (LOG2T-1);
    cr     = 22'(y_w) + 22'(i_w >>> 5) + 22'(q_w >>> 6);
    cg     = 22'(y_w) - 22'(i_w >>> 7) - 22'(q_w >>> 6);
    cb     = 22'(y_w) - 22'(i_w >>> 5) + 22'(q_w >>> 4);
    comp_r = clamp8(cr);
    comp_g = clamp8(cg);
    comp_b = clamp8(cb);
    mono   = (v1_q == 4'h0) ? 8'h00 : (!v1_q[3] ? 8'h55 : 8'hFF);

    p_d = p_q;   ptr_d = ptr_q;
    hy_d = hy_q; hi_d = hi_q; hq_d = hq_q;
    sy_d = sy_q; si_d = si_q; sq_d = sq_q;
    v1_d = v1_q; blank1_d = blank1_q; hs1_d = hs1_q; vs1_d = vs1_q;
    mode1_d = mode1_q; pal1_d = pal1_q;
    r2_d = r2_q; g2_d = g2_q; b2_d = b2_q; hs2_d = hs2_q; vs2_d = vs2_q;
    red_d = red_q; green_d = green_q; blue_d = blue_q; hso_d = hso_q; vso_d = vso_q;
    de_d = vif.pix_en;

    if (vif.pix_en) begin
      if (hs_rise) begin
        p_d   = '0;
        ptr_d = '0;
        sy_d  = '0; si_d = '0; sq_d = '0;
        for (int t = 0; t < TAPS; t++) begin
          hy_d[t] = '0; hi_d[t] = '0; hq_d[t] = '0;
        end
      end else begin
        sy_d = sy_q + 20'(s_new) - 20'(hy_q[ptr_q]);
        si_d = si_q + 20'(i_new) - 20'(hi_q[ptr_q]);
        sq_d = sq_q + 20'(q_new) - 20'(hq_q[ptr_q]);
        hy_d[ptr_q] = s_new;
        hi_d[ptr_q] = i_new;
        hq_d[ptr_q] = q_new;
        p_d   = p_q + 3'd1;
        ptr_d = ptr_q + LOG2T'(1);
      end

      v1_d     = vif.video;
      blank1_d = vif.blank;
      hs1_d    = vif.hsync;
      vs1_d    = vif.vsync;
      mode1_d  = (vif.mode == 2'b11) ? 2'b00 : vif.mode;
      pal1_d   = pal_q[vif.video];

      case (mode1_q)
        2'b01:   begin r2_d = comp_r[7 -: OUT_W]; g2_d = comp_g[7 -: OUT_W]; b2_d = comp_b[7 -: OUT_W]; end
        2'b10:   begin r2_d = '0; g2_d = mono[7 -: OUT_W]; b2_d = '0; end
        default: begin r2_d = pal1_q[OUT_W-1:0]; g2_d = pal1_q[2*OUT_W-1:OUT_W]; b2_d = pal1_q[PW-1:2*OUT_W]; end
      endcase
      if (blank1_q) begin
        r2_d = '0; g2_d = '0; b2_d = '0;
      end
      hs2_d = hs1_q;
      vs2_d = vs1_q;

      red_d = r2_q; green_d = g2_q; blue_d = b2_q;
      hso_d = hs2_q; vso_d = vs2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= pal_default(4'(i));
      for (int t = 0; t < TAPS; t++) begin
        hy_q[t] <= '0; hi_q[t] <= '0; hq_q[t] <= '0;
      end
      p_q <= '0; ptr_q <= '0;
      sy_q <= '0; si_q <= '0; sq_q <= '0;
      v1_q <= '0; blank1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0;
      mode1_q <= '0; pal1_q <= '0;
      r2_q <= '0; g2_q <= '0; b2_q <= '0; hs2_q <= 1'b0; vs2_q <= 1'b0;
      red_q <= '0; green_q <= '0; blue_q <= '0;
      hso_q <= 1'b0; vso_q <= 1'b0; de_q <= 1'b0;
    end else begin
      pal_q <= pal_d;
      hy_q <= hy_d; hi_q <= hi_d; hq_q <= hq_d;
      p_q <= p_d; ptr_q <= ptr_d;
      sy_q <= sy_d; si_q <= si_d; sq_q <= sq_d;
      v1_q <= v1_d; blank1_q <= blank1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
      mode1_q <= mode1_d; pal1_q <= pal1_d;
      r2_q <= r2_d; g2_q <= g2_d; b2_q <= b2_d; hs2_q <= hs2_d; vs2_q <= vs2_d;
      red_q <= red_d; green_q <= green_d; blue_q <= blue_d;
      hso_q <= hso_d; vso_q <= vso_d; de_q <= de_d;
    end
  end

  assign vif.red       = red_q;
  assign vif.green     = green_q;
  assign vif.blue      = blue_q;
  assign vif.hsync_out = hso_q;
  assign vif.vsync_out = vso_q;
  assign vif.de_out    = de_q;
endmodule

// File: tb/tb_cga_video_dac.sv
// Directed bench for cga_video_dac (OUT_W=6, TAPS=8) with hand-computed expected outputs.
module tb_cga_video_dac;
  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  cga_video_dac_if #(.OUT_W(6)) vif ();

  cga_video_dac #(.OUT_W(6), .TAPS(8), .LUMA_HI(21), .CHROMA_AMP(50)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vif     (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic chk_rgb(input string tag, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    chk({tag, ".r"}, 32'(vif.red),   32'(r));
    chk({tag, ".g"}, 32'(vif.green), 32'(g));
    chk({tag, ".b"}, 32'(vif.blue),  32'(b));
  endtask

  // Apply one clock of pixel inputs; outputs are sampled 1 ns after the edge.
  task automatic step(input logic [3:0] v, input logic [1:0] md, input logic bl,
                      input logic hs, input logic vs, input logic en);
    vif.video  = v;
    vif.mode   = md;
    vif.blank  = bl;
    vif.hsync  = hs;
    vif.vsync  = vs;
    vif.pix_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [3:0] v, input logic [1:0] md);
    step(v, md, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b0;
    vif.pix_en = 1'b0; vif.video = '0; vif.blank = 1'b0; vif.hsync = 1'b0;
    vif.vsync = 1'b0;  vif.mode = '0;  vif.pal_we = 1'b0; vif.pal_addr = '0;
    vif.pal_data = '0;
    #12;
    chk_rgb("reset", 6'h00, 6'h00, 6'h00);
    chk("reset.de", 32'(vif.de_out), 32'd0);
    chk("reset.hs", 32'(vif.hsync_out), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Default palette, 3-clock latency
    px(4'h6, 2'b00); px(4'h6, 2'b00); px(4'h6, 2'b00);
    chk_rgb("pal_brown", 6'h2A, 6'h15, 6'h00);
    chk("de_streaming", 32'(vif.de_out), 32'd1);
    px(4'hF, 2'b00); px(4'hF, 2'b00); px(4'hF, 2'b00);
    chk_rgb("pal_white", 6'h3F, 6'h3F, 6'h3F);

    // Palette write while streaming entry 6
    px(4'h6, 2'b00); px(4'h6, 2'b00);
    vif.pal_addr = 4'h6;
    vif.pal_data = {6'h00, 6'h00, 6'h3F};
    vif.pal_we   = 1'b1;
    px(4'h6, 2'b00);
    vif.pal_we   = 1'b0;
    px(4'h6, 2'b00);
    px(4'h6, 2'b00);
    chk_rgb("pal_same_cycle_old", 6'h2A, 6'h15, 6'h00);
    px(4'h6, 2'b00);
    chk_rgb("pal_after_write", 6'h3F, 6'h00, 6'h00);

    // Mode sampled per pixel, mono levels, blank, mode 11
    px(4'h9, 2'b10);
    px(4'h9, 2'b00);
    px(4'h2, 2'b10);
    chk_rgb("mono_int", 6'h00, 6'h3F, 6'h00);
    px(4'h0, 2'b10);
    chk_rgb("pal_lblue", 6'h15, 6'h15, 6'h3F);
    step(4'hF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_rgb("mono_dim", 6'h00, 6'h15, 6'h00);
    step(4'hF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_rgb("mono_black", 6'h00, 6'h00, 6'h00);
    px(4'hE, 2'b11);
    chk_rgb("mono_blank", 6'h00, 6'h00, 6'h00);
    px(4'h0, 2'b00);
    chk_rgb("pal_blank", 6'h00, 6'h00, 6'h00);
    px(4'h0, 2'b00);
    chk_rgb("mode11_yellow", 6'h3F, 6'h3F, 6'h15);

    // Composite: hsync edge clears phase and filter
    step(4'hF, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    step(4'hF, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    px(4'hF, 2'b01);
    chk("hsync_aligned", 32'(vif.hsync_out), 32'd1);
    chk_rgb("comp_hs_pixel", 6'h00, 6'h00, 6'h00);
    px(4'hF, 2'b01);
    chk("vsync_aligned", 32'(vif.vsync_out), 32'd1);
    chk("hsync_drop", 32'(vif.hsync_out), 32'd0);
    chk_rgb("comp_single", 6'h06, 6'h0C, 6'h00);
    px(4'hF, 2'b01);
    chk_rgb("comp_two", 6'h14, 6'h16, 6'h00);
    for (int i = 0; i < 16; i++) px(4'hF, 2'b01);
    chk_rgb("comp_white", 6'h3F, 6'h3F, 6'h3F);
    for (int i = 0; i < 16; i++) px(4'h0, 2'b01);
    chk_rgb("comp_black", 6'h00, 6'h00, 6'h00);
    step(4'h0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    px(4'hF, 2'b01);
    px(4'hF, 2'b01);
    px(4'hF, 2'b01);
    chk_rgb("comp_second_line", 6'h06, 6'h0C, 6'h00);

    // pix_en one strobe in three: stages hold between strobes
    step(4'h1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("de_idle", 32'(vif.de_out), 32'd0);
    step(4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("de_strobe", 32'(vif.de_out), 32'd1);
    chk_rgb("gated_blue", 6'h00, 6'h00, 6'h2A);
    step(4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_rgb("gated_hold", 6'h00, 6'h00, 6'h2A);
    step(4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_rgb("gated_green", 6'h00, 6'h2A, 6'h00);

    // Reset mid-line restores palette defaults and clears outputs at once
    px(4'h6, 2'b00); px(4'h6, 2'b00); px(4'h6, 2'b00);
    chk_rgb("pal_persist", 6'h3F, 6'h00, 6'h00);
    #2;
    reset_n = 1'b0;
    #1;
    chk_rgb("async_reset", 6'h00, 6'h00, 6'h00);
    chk("async_reset.de", 32'(vif.de_out), 32'd0);
    #3;
    reset_n = 1'b1;
    px(4'h6, 2'b00); px(4'h6, 2'b00);
    chk_rgb("post_reset_fill", 6'h00, 6'h00, 6'h00);
    px(4'h6, 2'b00);
    chk_rgb("post_reset_brown", 6'h2A, 6'h15, 6'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
